// File: rtl/s_axis_frame_rx.sv
// AXI4-Stream frame receiver: buffers one frame in block RAM, then replays it with backpressure.
// Optional strobe checking is built when S_AXIS_TSTRB_CHECK_EN is defined.
module s_axis_frame_rx #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int FRAME_LEN = 800
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                s_axis_tvalid,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [DATA_W/8-1:0] s_axis_tstrb,
    input  logic                s_axis_tlast,
    output logic                s_axis_tready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    output logic                out_last,
    input  logic                out_ready,
    output logic [ADDR_W:0]     frame_len,
    output logic                len_err,
    output logic                ovf_err,
    output logic                strb_err
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {IDLE, RECV, FLUSH, DRAIN} state_t;

    state_t              state;
    logic [ADDR_W:0]     wr_cnt;
    logic [ADDR_W:0]     rd_ptr;
    logic [ADDR_W+1:0]   beat_cnt;
    logic [ADDR_W+1:0]   bcnt_inc;
    logic                dvalid;
    logic                dlast;
    logic [DATA_W-1:0]   rd_data;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic accept, wr_en, rd_en, load_out, consume, len_bad, full;

    assign accept   = s_axis_tvalid && s_axis_tready;
    assign full     = wr_cnt[ADDR_W];
    assign wr_en    = accept && (state == IDLE || state == RECV) && !full;
    assign consume  = out_valid && out_ready;
    assign rd_en    = (state == DRAIN) && (!out_valid || out_ready) && (rd_ptr < frame_len);
    // RAM output is held between reads, so dvalid marks a word parked there
    assign load_out = dvalid && (!out_valid || out_ready);
    assign bcnt_inc = (state == IDLE) ? (ADDR_W+2)'(1) :
                      (&beat_cnt)     ? beat_cnt : beat_cnt + 1'b1;
    assign len_bad  = bcnt_inc != (ADDR_W+2)'(FRAME_LEN);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_cnt[ADDR_W-1:0]] <= s_axis_tdata;
        if (rd_en) rd_data <= mem[rd_ptr[ADDR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            s_axis_tready <= 1'b0;
            wr_cnt        <= '0;
            rd_ptr        <= '0;
            beat_cnt      <= '0;
            dvalid        <= 1'b0;
            dlast         <= 1'b0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            frame_len     <= '0;
            len_err       <= 1'b0;
            ovf_err       <= 1'b0;
        end else begin
            len_err       <= 1'b0;
            s_axis_tready <= 1'b1;
            case (state)
                IDLE, RECV, FLUSH: begin
                    if (accept) begin
                        beat_cnt <= bcnt_inc;
                        if (wr_en) wr_cnt <= wr_cnt + 1'b1;
                        if (state == RECV && full) ovf_err <= 1'b1;
                        if (s_axis_tlast) begin
                            state         <= DRAIN;
                            s_axis_tready <= 1'b0;
                            len_err       <= len_bad;
                            frame_len     <= wr_en ? wr_cnt + 1'b1 : wr_cnt;
                        end else if (state == IDLE) begin
                            state <= RECV;
                        end else if (full) begin
                            state <= FLUSH;
                        end
                    end
                end
                DRAIN: begin
                    s_axis_tready <= 1'b0;
                    if (rd_en) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        dvalid <= 1'b1;
                        dlast  <= (rd_ptr == frame_len - (ADDR_W+1)'(1));
                    end else if (load_out) begin
                        dvalid <= 1'b0;
                    end
                    if (load_out) begin
                        out_data  <= rd_data;
                        out_valid <= 1'b1;
                        out_last  <= dlast;
                    end else if (consume) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                    if (consume && out_last) begin
                        state         <= IDLE;
                        s_axis_tready <= 1'b1;
                        wr_cnt        <= '0;
                        rd_ptr        <= '0;
                        dvalid        <= 1'b0;
                        out_valid     <= 1'b0;
                        out_last      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef S_AXIS_TSTRB_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rstn)
            strb_err <= 1'b0;
        else if (accept && s_axis_tstrb != '1)
            strb_err <= 1'b1;
    end
`else
    logic unused_strb;
    assign unused_strb = ^s_axis_tstrb;
    assign strb_err    = 1'b0;
`endif

endmodule

// File: tb/tb_s_axis_frame_rx.sv
// Directed bench for s_axis_frame_rx: nominal, backpressure, short, overflow, mid-drain reset, strobe.
module tb_s_axis_frame_rx;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;

    logic                clk = 1'b0;
    logic                rstn;
    logic                tvalid;
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic                tlast;
    logic                tready;
    logic [DATA_W-1:0]   out_data;
    logic                out_valid;
    logic                out_last;
    logic                out_ready;
    logic [ADDR_W:0]     frame_len;
    logic                len_err;
    logic                ovf_err;
    logic                strb_err;

    int checks   = 0;
    int failures = 0;
    bit exp_strb;

    always #5 clk = ~clk;

    s_axis_frame_rx #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_LEN(800)) dut (
        .clk(clk), .rstn(rstn),
        .s_axis_tvalid(tvalid), .s_axis_tdata(tdata), .s_axis_tstrb(tstrb),
        .s_axis_tlast(tlast), .s_axis_tready(tready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .frame_len(frame_len), .len_err(len_err), .ovf_err(ovf_err), .strb_err(strb_err)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_tready"},   tready,    0);
        chk({tag, "_ovalid"},   out_valid, 0);
        chk({tag, "_olast"},    out_last,  0);
        chk({tag, "_odata"},    out_data,  0);
        chk({tag, "_flen"},     frame_len, 0);
        chk({tag, "_len_err"},  len_err,   0);
        chk({tag, "_ovf_err"},  ovf_err,   0);
        chk({tag, "_strb_err"}, strb_err,  0);
    endtask

    // Send n beats of data base+i, then drain and score against the expected word stream.
    task automatic do_frame(input string tag, input int n, input int base, input bit bp,
                            input int exp_words, input bit exp_lerr, input int bad_beat,
                            input int abort_at);
        int stall = 0, wait_c, c = 0, idx = 0, first = -1, lerr_cnt;
        int ord_err = 0, last_err = 0, stab_err = 0, trdy_err = 0;
        bit stalled = 0, pl = 0;
        logic [DATA_W-1:0] pd = '0;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            tvalid = 1'b1;
            tdata  = DATA_W'(base + i);
            tlast  = (i == n - 1);
            tstrb  = (i == bad_beat) ? 4'b0111 : 4'hF;
            wait_c = 0;
            while (!tready && wait_c < 50) begin
                @(posedge clk); #1;
                wait_c++;
                stall++;
            end
            if (!tready) begin
                chk({tag, "_tready_timeout"}, tready, 1);
                tvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tstrb  = 4'hF;
        chk({tag, "_send_stall"}, stall, 0);
        chk({tag, "_frame_len"}, frame_len, exp_words);
        chk({tag, "_strb_err"}, strb_err, exp_strb);
        lerr_cnt = len_err;
        while (idx < exp_words && c < 6000 && !(abort_at > 0 && idx >= abort_at)) begin
            out_ready = bp ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
            if (tready) trdy_err++;
            if (out_valid && first < 0) first = c;
            if (stalled && (!out_valid || out_data !== pd || out_last !== pl)) stab_err++;
            if (out_valid && out_ready) begin
                if (out_data !== DATA_W'(base + idx)) ord_err++;
                if (out_last !== (idx == exp_words - 1)) last_err++;
                idx++;
            end
            stalled = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            @(posedge clk); #1;
            c++;
            if (len_err) lerr_cnt++;
        end
        chk({tag, "_first_valid"}, first, 2);
        chk({tag, "_order"}, ord_err, 0);
        chk({tag, "_last"}, last_err, 0);
        chk({tag, "_stable"}, stab_err, 0);
        chk({tag, "_tready_drain"}, trdy_err, 0);
        chk({tag, "_len_err_pulses"}, lerr_cnt, exp_lerr);
        if (abort_at > 0) begin
            chk({tag, "_abort_idx"}, idx, abort_at);
            return;
        end
        chk({tag, "_words"}, idx, exp_words);
        chk({tag, "_done_ovalid"}, out_valid, 0);
        chk({tag, "_done_tready"}, tready, 1);
        out_ready = 1'b1;
    endtask

    initial begin
`ifdef S_AXIS_TSTRB_CHECK_EN
        bit strb_on = 1;
`else
        bit strb_on = 0;
`endif
        exp_strb  = 0;
        rstn      = 1'b0;
        tvalid    = 1'b0;
        tdata     = '0;
        tstrb     = 4'hF;
        tlast     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("por");
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("por_tready_release", tready, 1);

        do_frame("nom", 800, 0, 0, 800, 0, -1, 0);
        do_frame("bp", 800, 1000, 1, 800, 0, -1, 0);
        do_frame("short", 10, 5000, 0, 10, 1, -1, 0);
        do_frame("after_short", 800, 7000, 0, 800, 0, -1, 0);
        chk("pre_ovf_ovf_err", ovf_err, 0);
        do_frame("ovf", 1030, 0, 0, 1024, 1, -1, 0);
        chk("ovf_ovf_err", ovf_err, 1);

        do_frame("abort", 800, 20000, 0, 800, 0, -1, 400);
        rstn = 1'b0;
        @(posedge clk); #1;
        reset_checks("rst_mid");
        rstn = 1'b1;
        chk("rst_mid_tready_pre", tready, 0);
        @(posedge clk); #1;
        chk("rst_mid_tready_post", tready, 1);
        do_frame("post_rst", 800, 30000, 0, 800, 0, -1, 0);

        exp_strb = strb_on;
        do_frame("strb", 800, 40000, 1, 800, 0, 5, 0);
        chk("strb_sticky", strb_err, strb_on);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
